led_sweeper: RTL and testbench

//   Parametrised one-hot LED sweeper: a single lit LED walks across NUM_LEDS

---
 rtl/led_sweeper.sv | 153 +++++++++++++++
 tb/tb_led_sweeper.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_sweeper.sv
// ---------------------------------------------------------------------------
// led_sweeper
//   One-hot LED sweeper. A single lit LED walks across NUM_LEDS outputs; the
//   step rate comes from a down-counting prescaler that reloads with
//   {delay, SHIFT'b0} on every tick, giving a period of delay*2^SHIFT + 1
//   cycles. The walk pattern is chosen by mode: bounce, wrap-up, wrap-down
//   or hold.
//
// Ports
//   clk         system clock, all state updates on the rising edge
//   reset_n     asynchronous active-low reset
//   enable      1 = prescaler runs, 0 = count/pos/dir frozen
//   delay       step period select, sampled only at reload
//   mode        00 bounce, 01 wrap-up, 10 wrap-down, 11 hold
//   led         registered one-hot output, led == 1 << pos
//   step_pulse  registered, high for one cycle per tick
// ---------------------------------------------------------------------------
module led_sweeper #(
    parameter int NUM_LEDS   = 4,
    parameter int DELAY_BITS = 4,
    parameter int SHIFT      = 22
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [DELAY_BITS-1:0] delay,
    input  logic [1:0]            mode,
    output logic [NUM_LEDS-1:0]   led,
    output logic                  step_pulse
);

    localparam int POS_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int CNT_W = DELAY_BITS + SHIFT;

    localparam logic [POS_W-1:0] POS_ZERO = '0;
    localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);
    // Last valid position; wrap compares against this rather than relying on
    // 2^POS_W overflow, so non-power-of-two LED counts wrap correctly.
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(NUM_LEDS - 1);

    typedef enum logic [1:0] {
        MODE_BOUNCE    = 2'b00,
        MODE_WRAP_UP   = 2'b01,
        MODE_WRAP_DOWN = 2'b10,
        MODE_HOLD      = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    logic [CNT_W-1:0]    count_q, count_d;
    logic [POS_W-1:0]    pos_q, pos_d;
    dir_e                dir_q, dir_d;
    logic [NUM_LEDS-1:0] led_q, led_d;
    logic                step_pulse_q, step_pulse_d;

    logic [POS_W-1:0]    next_pos;
    dir_e                next_dir;
    logic                tick;

    // A tick needs both an expired count and enable; with enable low the
    // count parks at zero and the tick fires on the first enabled edge.
    assign tick = (count_q == '0) && enable;

    // Where the LED would go if a tick happened now, given the sampled mode.
    always_comb begin : step_logic
        // NOTE: every signal driven here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        next_pos = pos_q;
        next_dir = dir_q;
        case (mode_e'(mode))
            MODE_BOUNCE: begin
                // A single LED has nowhere to go; also keeps pos-1 from
                // underflowing below.
                if (NUM_LEDS > 1) begin
                    if (dir_q == DIR_UP) begin
                        // At an endpoint reverse and step in the same tick.
                        if (pos_q == POS_LAST) begin
                            next_dir = DIR_DOWN;
                            next_pos = pos_q - POS_ONE;
                        end else begin
                            next_pos = pos_q + POS_ONE;
                        end
                    end else begin
                        if (pos_q == POS_ZERO) begin
                            next_dir = DIR_UP;
                            next_pos = pos_q + POS_ONE;
                        end else begin
                            next_pos = pos_q - POS_ONE;
                        end
                    end
                end
            end
            MODE_WRAP_UP: begin
                next_dir = DIR_UP;
                next_pos = (pos_q == POS_LAST) ? POS_ZERO : pos_q + POS_ONE;
            end
            MODE_WRAP_DOWN: begin
                next_dir = DIR_DOWN;
                next_pos = (pos_q == POS_ZERO) ? POS_LAST : pos_q - POS_ONE;
            end
            default: begin
                // Hold: position and direction stay put, prescaler keeps running.
                next_pos = pos_q;
                next_dir = dir_q;
            end
        endcase
    end

    always_comb begin : next_state
        count_d      = count_q;
        pos_d        = pos_q;
        dir_d        = dir_q;
        step_pulse_d = 1'b0;
        if (tick) begin
            // delay is only looked at here, so a change mid-countdown lets the
            // current period finish before the new one applies.
            count_d      = CNT_W'(delay) << SHIFT;
            pos_d        = next_pos;
            dir_d        = next_dir;
            step_pulse_d = 1'b1;
        end else if (enable) begin
            count_d = count_q - CNT_W'(1);
        end
        // Decoded from pos_d so led is registered and moves on the same edge
        // as pos.
        led_d = NUM_LEDS'(1) << pos_d;
    end

    // NOTE: state flops use non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q      <= '0;
            pos_q        <= '0;
            dir_q        <= DIR_UP;
            led_q        <= NUM_LEDS'(1);
            step_pulse_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            pos_q        <= pos_d;
            dir_q        <= dir_d;
            led_q        <= led_d;
            step_pulse_q <= step_pulse_d;
        end
    end

    assign led        = led_q;
    assign step_pulse = step_pulse_q;

endmodule

// File: tb/tb_led_sweeper.sv
// ---------------------------------------------------------------------------
// tb_led_sweeper
//   Three sweepers (4, 5 and 1 LEDs, SHIFT=2). Stimulus pushes the expected
//   LED value and the expected cycle gap since the previous step into a
//   per-instance queue; a monitor pops one entry for every step_pulse and
//   checks that led never moves or goes non-one-hot between steps.
// ---------------------------------------------------------------------------
module tb_led_sweeper;

    typedef struct {
        int led;
        int gap;   // cycles since previous step; 0 = not checked
    } sb_t;

    logic       clk;
    logic       reset_n;
    logic       en4, en5, en1;
    logic [3:0] delay4, delay5, delay1;
    logic [1:0] mode4, mode5, mode1;
    logic [3:0] led4;
    logic [4:0] led5;
    logic [0:0] led1;
    logic       pulse4, pulse5, pulse1;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    sb_t exp4_q[$];
    sb_t exp5_q[$];
    sb_t exp1_q[$];

    led_sweeper #(.NUM_LEDS(4), .DELAY_BITS(4), .SHIFT(2)) u_d4 (
        .clk(clk), .reset_n(reset_n), .enable(en4), .delay(delay4),
        .mode(mode4), .led(led4), .step_pulse(pulse4));

    led_sweeper #(.NUM_LEDS(5), .DELAY_BITS(4), .SHIFT(2)) u_d5 (
        .clk(clk), .reset_n(reset_n), .enable(en5), .delay(delay5),
        .mode(mode5), .led(led5), .step_pulse(pulse5));

    led_sweeper #(.NUM_LEDS(1), .DELAY_BITS(4), .SHIFT(2)) u_d1 (
        .clk(clk), .reset_n(reset_n), .enable(en1), .delay(delay1),
        .mode(mode1), .led(led1), .step_pulse(pulse1));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic extra_pulse(input string name, input int led_val);
        checks++;
        errors++;
        $display("FAIL %s_extra_step: step with led 0x%0h expected no step (cycle %0d)", name, led_val, cyc);
    endtask

    task automatic score(input string name, input int led_val, input sb_t e, input int gap);
        check({name, "_led"}, led_val, e.led);
        if (e.gap != 0) check({name, "_gap"}, gap, e.gap);
    endtask

    task automatic push4(input int led_val, input int gap);
        sb_t e;
        e.led = led_val;
        e.gap = gap;
        exp4_q.push_back(e);
    endtask

    // ---------------------------------------------------------------- monitors
    int  last4, last5, last1;
    int  prev4, prev5, prev1;
    sb_t e4, e5, e1;

    always @(negedge clk) begin
        if (!reset_n) begin
            prev4 = int'(led4);
            last4 = cyc;
        end else begin
            check("d4_onehot", int'($onehot(led4)), 1);
            if (pulse4) begin
                if (exp4_q.size() == 0) extra_pulse("d4", int'(led4));
                else begin
                    e4 = exp4_q.pop_front();
                    score("d4", int'(led4), e4, cyc - last4);
                end
                last4 = cyc;
            end else begin
                check("d4_stable", int'(led4), prev4);
            end
            prev4 = int'(led4);
        end
    end

    always @(negedge clk) begin
        if (!reset_n) begin
            prev5 = int'(led5);
            last5 = cyc;
        end else begin
            check("d5_onehot", int'($onehot(led5)), 1);
            if (pulse5) begin
                if (exp5_q.size() == 0) extra_pulse("d5", int'(led5));
                else begin
                    e5 = exp5_q.pop_front();
                    score("d5", int'(led5), e5, cyc - last5);
                end
                last5 = cyc;
            end else begin
                check("d5_stable", int'(led5), prev5);
            end
            prev5 = int'(led5);
        end
    end

    always @(negedge clk) begin
        if (!reset_n) begin
            prev1 = int'(led1);
            last1 = cyc;
        end else begin
            check("d1_led", int'(led1), 1);
            if (pulse1) begin
                if (exp1_q.size() == 0) extra_pulse("d1", int'(led1));
                else begin
                    e1 = exp1_q.pop_front();
                    score("d1", int'(led1), e1, cyc - last1);
                end
                last1 = cyc;
            end
            prev1 = int'(led1);
        end
    end

    // Returns #1 after the negedge on which the last queued step was popped.
    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while ((exp4_q.size() + exp5_q.size() + exp1_q.size()) != 0 && n < budget);
        check("steps_pending", exp4_q.size() + exp5_q.size() + exp1_q.size(), 0);
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        reset_n = 1'b0;
        en4 = 1'b0; en5 = 1'b0; en1 = 1'b0;
        delay4 = 4'd1; delay5 = 4'd0; delay1 = 4'd0;
        mode4 = 2'b00; mode5 = 2'b01; mode1 = 2'b00;

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        check("reset_led4", int'(led4), 1);
        check("reset_pulse4", int'(pulse4), 0);
        check("reset_led5", int'(led5), 1);
        check("reset_led1", int'(led1), 1);

        // Bounce, delay=1: first tick on first edge, then every 5 cycles.
        push4(4'b0010, 0);
        push4(4'b0100, 5);
        push4(4'b1000, 5);
        push4(4'b0100, 5);
        push4(4'b0010, 5);
        push4(4'b0001, 5);
        push4(4'b0010, 5);
        push4(4'b0100, 5);
        reset_n = 1'b1;
        en4     = 1'b1;
        wait_drain(60);

        // Now at pos=2 with step_pulse high: asynchronous reset mid-sweep.
        check("pre_reset_led4", int'(led4), 4'b0100);
        reset_n = 1'b0;
        #1;
        check("async_reset_led4", int'(led4), 1);
        check("async_reset_pulse4", int'(pulse4), 0);

        // Wrap-up at delay=0, then wrap-down from pos=1.
        mode4  = 2'b01;
        delay4 = 4'd0;
        repeat (2) @(negedge clk);
        push4(4'b0010, 0);
        push4(4'b0100, 1);
        push4(4'b1000, 1);
        push4(4'b0001, 1);
        push4(4'b0010, 1);
        push4(4'b0001, 1);
        push4(4'b1000, 1);
        push4(4'b0100, 1);
        #1 reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1 mode4 = 2'b10;
        repeat (3) @(posedge clk);
        #1 en4 = 1'b0;
        wait_drain(20);

        // Hold, delay=1, with one disabled edge at count==0 first; then a
        // 7-cycle freeze mid-countdown stretches one period from 5 to 12.
        mode4  = 2'b11;
        delay4 = 4'd1;
        push4(4'b0100, 0);
        push4(4'b0100, 5);
        push4(4'b0100, 12);
        push4(4'b0100, 5);
        @(posedge clk);
        #1 en4 = 1'b1;
        repeat (8) @(posedge clk);
        #1 en4 = 1'b0;
        repeat (7) @(posedge clk);
        #1 en4 = 1'b1;
        wait_drain(40);

        // Delay 1->3 two cycles after a tick, switching to wrap-up as well:
        // the running 5-cycle period completes, then 13-cycle periods.
        push4(4'b1000, 5);
        push4(4'b0001, 13);
        push4(4'b0010, 13);
        repeat (2) @(posedge clk);
        #1;
        delay4 = 4'd3;
        mode4  = 2'b01;
        wait_drain(50);

        // Wrap-down to pos 0 (dir down), then bounce: reverse before stepping.
        delay4 = 4'd0;
        mode4  = 2'b10;
        push4(4'b0001, 13);
        wait_drain(20);
        mode4 = 2'b00;
        push4(4'b0010, 1);
        push4(4'b0100, 1);
        repeat (2) @(posedge clk);
        #1 en4 = 1'b0;
        wait_drain(10);

        // Five LEDs wrap at 4, never reaching pos 5..7; one LED stays lit.
        for (int i = 0; i < 6; i++) begin
            sb_t e;
            e.gap = (i == 0) ? 0 : 1;
            e.led = 1 << ((i + 1) % 5);
            exp5_q.push_back(e);
            e.led = 1;
            exp1_q.push_back(e);
        end
        en5 = 1'b1;
        en1 = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        en5 = 1'b0;
        en1 = 1'b0;
        wait_drain(10);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
